// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit for the execute stage.
// Multiplies with one shift-add step per clock and divides with one restoring step per clock, working on operand magnitudes.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       count;
    logic [2:0]          op;
    logic [XLEN-1:0]     operand;
    logic [2*XLEN-1:0]   acc;
    logic                neg_main, neg_rem;

    logic                accept, is_div, a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                div_zero, overflow, special;
    logic [XLEN-1:0]     special_val;
    logic [XLEN:0]       sum;
    logic [2*XLEN-1:0]   mul_next, div_next;
    logic [XLEN:0]       shifted;
    logic [XLEN-1:0]     diff;
    logic                borrow;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    // Operand decode, sign handling and the special cases resolved at accept time
    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        is_div   = funct3[2];
        a_signed = is_div ? !funct3[0] : (funct3 != 3'b011);
        b_signed = is_div ? !funct3[0] : !funct3[1];
        sign_a   = a_signed && a[XLEN-1];
        sign_b   = b_signed && b[XLEN-1];
        abs_a    = sign_a ? -a : a;
        abs_b    = sign_b ? -b : b;
        div_zero = is_div && (b == '0);
        overflow = is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special  = div_zero || overflow;
        if (div_zero)
            special_val = funct3[1] ? a : '1;
        else
            special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {sum, acc[XLEN-1:1]};
        shifted  = acc[2*XLEN-1:XLEN-1];
        borrow   = shifted < {1'b0, operand};
        diff     = shifted[XLEN-1:0] - operand;
        div_next = borrow ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {diff, acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_main ? -acc : acc;
        quo_fix  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:         fix_val = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fix_val = quo_fix;
            3'b110, 3'b111: fix_val = rem_fix;
            default:        fix_val = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            CALC:    if (flush) state_next = IDLE;
                     else if (count == CW'(XLEN-1)) state_next = FIX;
            FIX:     state_next = flush ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept)
            state_next = special ? DONE : CALC;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Datapath; a flush simply stops updates so result keeps its old value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            op       <= '0;
            operand  <= '0;
            acc      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            count    <= '0;
            op       <= funct3;
            operand  <= abs_b;
            acc      <= {{XLEN{1'b0}}, abs_a};
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            if (special)
                result <= special_val;
        end else if (state == CALC && !flush) begin
            acc   <= op[2] ? div_next : mul_next;
            count <= count + 1'b1;
        end else if (state == FIX && !flush) begin
            result <= fix_val;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: expected results are queued at issue and popped when done pulses.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          accept_cyc = 0;
    int          busy_seen = 0;
    logic [31:0] last_result = '0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drives one request for a single edge, then scrambles the operands to prove they were latched
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] expv, input bit push);
        funct3 = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        funct3 = 3'($urandom);
    endtask

    task automatic checkOutput(input string tag, input int exp_lat, input bit expect_drop);
        int n;
        logic [31:0] expv;
        n = 0;
        busy_seen = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_seen++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        check({tag, "_latency"}, 32'(cyc - accept_cyc), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            expv = exp_q.pop_front();
            check(tag, result, expv);
            last_result = expv;
        end
        if (expect_drop) begin
            @(posedge clk);
            #1;
            check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        int done_cnt;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'b000;
        a       = '0;
        b       = '0;
        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1);
        checkOutput("mul", 33, 1);
        check("mul_busy_cycles", 32'(busy_seen), 32'd33);

        applyStimulus(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1);
        checkOutput("mulh", 33, 1);
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        checkOutput("mulhu", 33, 1);
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        checkOutput("mulhsu", 33, 1);

        applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1);
        checkOutput("div", 33, 1);
        applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1);
        checkOutput("rem", 33, 1);
        applyStimulus(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 1);
        checkOutput("divu", 33, 1);
        applyStimulus(3'b111, 32'hFFFFFFF9, 32'd2, 32'd1, 1);
        checkOutput("remu", 33, 1);

        applyStimulus(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        checkOutput("div_by_zero", 0, 1);
        check("div_by_zero_busy", 32'(busy_seen), 32'd0);
        applyStimulus(3'b111, 32'd5, 32'd0, 32'd5, 1);
        checkOutput("remu_by_zero", 0, 1);
        applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        checkOutput("div_overflow", 0, 1);
        applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        checkOutput("rem_overflow", 0, 1);

        // A second start while busy must be dropped
        applyStimulus(3'b000, 32'd6, 32'd9, 32'd54, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        funct3 = 3'b000;
        a      = 32'd100;
        b      = 32'd100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        check("ignored_start_busy", {31'b0, busy}, 32'd1);
        checkOutput("mul_ignored_start", 33, 1);

        applyStimulus(3'b000, 32'd3, 32'd4, 32'd12, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, last_result);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("flush_no_done", 32'(done_cnt), 32'd0);
        check("flush_result_held", result, last_result);

        flush = 1'b1;
        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, 1);
        flush = 1'b0;
        checkOutput("divu_flush_idle", 33, 1);

        // Asynchronous reset in the middle of a divide
        applyStimulus(3'b100, 32'd1000, 32'd3, 32'd0, 0);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("midop_reset_busy", {31'b0, busy}, 32'd0);
        check("midop_reset_done", {31'b0, done}, 32'd0);
        check("midop_reset_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, 1);
        checkOutput("divu_b2b", 33, 0);
        applyStimulus(3'b111, 32'd100, 32'd7, 32'd2, 1);
        checkOutput("remu_b2b", 33, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit beside the single-cycle ALU in the execute stage.
- Consumes the same register operands (a = rs1, b = rs2) and writes its result into the writeback result mux in place of the ALU result.
- The controller stalls the PC while busy is high.
- Radix-2: one partial product or quotient bit per clock, so area stays small.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the counter width is derived as log2(XLEN)+1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand (multiplicand / dividend)
- b  in  XLEN  rs2 operand (multiplier / divisor)
- flush  in  1  abort the in-flight op (pipeline kill)
- busy  out  1  op in progress; not accepting start
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  final value, held until the next accepted start

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low.
  - reset_n=0 forces state IDLE, busy=0, done=0, result=0, counter=0, internal registers 0.
  - This holds at any time, including mid-operation.
- States:
  - IDLE, CALC, FIX, DONE.
  - busy=1 only in CALC and FIX.
  - done=1 only in DONE.
- Accept:
  - A start is accepted when the state is IDLE or DONE (back-to-back allowed).
  - On acceptance, funct3, a and b are latched at edge k.
  - Operands may change after edge k.
  - start while busy=1 is ignored; no queuing.
- Operand prep at accept:
  - Signed ops take magnitudes of the signed operands and record sign flags.
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Special cases, decided at accept (go directly to DONE at edge k, so done is high in the cycle after edge k):
  - Divide by zero (b=0, any div/rem op): DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- Normal path (IDLE/DONE → CALC at edge k, counter=0):
  - MUL*: 64-bit shift-add on magnitudes, one multiplier bit per edge.
  - DIV*/REM*: restoring division on magnitudes, one quotient bit per edge; 33-bit subtract, restore on borrow.
  - CALC holds for 32 edges (k+1..k+32); counter reaches 31 and the state moves to FIX at edge k+32.
- FIX, one edge (k+33), then DONE:
  - Product is negated if the sign flags differ.
  - Quotient is negated if the signs of a and b differ.
  - Remainder takes the sign of a.
  - MUL selects product[31:0]; MULH/MULHSU/MULHU select product[63:32].
- Latency:
  - done is high in the cycle after edge k+33 (33 cycles after the accept edge).
  - DONE lasts exactly one cycle, then the state returns to IDLE unless start is accepted.
  - result is registered and changes only when DONE is entered.
- Flush:
  - flush=1 in CALC or FIX: the next edge goes to IDLE with no done pulse, and result keeps its previous value.
  - flush in IDLE or DONE has no effect.
  - flush and start in the same cycle in IDLE/DONE: flush has no effect there, so the start is accepted.
- Arithmetic:
  - All results are mod 2^32.
  - Negation is two's complement.
  - The 0x80000000 magnitude is handled as an unsigned 32-bit value.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB; done exactly 33 cycles after the accept edge; busy high 33 cycles.
- MULH a=b=0x80000000 → 0x40000000; MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU a=0xFFFFFFF9, b=2 → 0x7FFFFFFC; REMU same → 1.
- DIV a=5, b=0 → 0xFFFFFFFF and REMU a=5, b=0 → 5, each with done one cycle after accept; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 and REM → 0, each in one cycle.
- Start MUL; pulse start with new operands at cycle 5 → ignored, original result returned. Flush at cycle 10 → IDLE next cycle, no done, prior result unchanged.
- reset_n low at cycle 15 of a DIV → busy=0, done=0, result=0 immediately (asynchronous); after release, back-to-back DIVU 100/7 then REMU 100/7 (start held high in DONE) → 14 then 2.
